v_dsampler_ctrl: RTL and testbench

V_DSAMPLER_CTRL -- requirements
Module: v_dsampler_ctrl

---
 rtl/v_dsampler_ctrl_if.sv | 14 +
 rtl/v_dsampler_ctrl.sv | 127 ++++++++++++
 tb/tb_v_dsampler_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/v_dsampler_ctrl_if.sv
// AXI4-Stream video beat bundle shared by the slave and master sides of the down-sampler controller.
// The master drives valid/data/last/user and the slave drives ready.
interface v_dsampler_ctrl_if #(
   parameter int DATA_WIDTH = 48
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;
   logic                  tuser;

   modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
   modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/v_dsampler_ctrl.sv
// Frame gate for the down-sampler: forwards SOF-aligned frames, latches decimation config per frame, checks geometry.
// Zero-latency combinational pass-through; s_axis.tready mirrors m_axis.tready while forwarding, else beats are sunk.
module v_dsampler_ctrl #(
   parameter int DATA_WIDTH = 48,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 cfg_wr,
   input  logic                 cfg_enable,
   input  logic                 cfg_col_down,
   input  logic                 cfg_line_down,
   input  logic [CNT_WIDTH-1:0] cfg_width,
   input  logic [CNT_WIDTH-1:0] cfg_height,
   input  logic                 err_clr,
   v_dsampler_ctrl_if.slave     s_axis,
   v_dsampler_ctrl_if.master    m_axis,
   output logic                 ds_col_down,
   output logic                 ds_line_down,
   output logic [CNT_WIDTH-1:0] frame_cnt,
   output logic                 err_line_len,
   output logic                 err_frame,
   output logic                 busy
);
   typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   state_t                state, state_nxt;
   logic                  sh_en, sh_col, sh_line;
   logic [CNT_WIDTH-1:0]  sh_width, sh_height;
   logic [CNT_WIDTH-1:0]  act_width, act_height;
   logic [CNT_WIDTH-1:0]  beat_cnt, line_cnt;
   logic [CNT_WIDTH-1:0]  cur_w, cur_h, beat_idx, line_idx;
   logic [DATA_WIDTH-1:0] pass_dat;
   logic                  sof, fwd, fire, at_end, eof, line_err;

   assign pass_dat     = s_axis.tdata;
   assign m_axis.tdata = pass_dat;
   assign m_axis.tlast = s_axis.tlast;
   assign m_axis.tuser = s_axis.tuser;
   assign busy         = (state == ACTIVE);

   // An SOF beat is beat 0 of line 0 and is judged against the geometry it is about to load.
   assign sof      = s_axis.tuser;
   assign fwd      = (state == ACTIVE) || (state == WAIT_SOF && sh_en && sof);
   assign fire     = fwd && s_axis.tvalid && m_axis.tready;
   assign cur_w    = sof ? ((sh_width  == '0) ? ONE : sh_width)  : act_width;
   assign cur_h    = sof ? ((sh_height == '0) ? ONE : sh_height) : act_height;
   assign beat_idx = sof ? '0 : beat_cnt;
   assign line_idx = sof ? '0 : line_cnt;
   assign at_end   = (beat_idx == cur_w - ONE);
   assign eof      = fire && s_axis.tlast && (line_idx == cur_h - ONE);
   assign line_err = fire && (s_axis.tlast != at_end);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      m_axis.tvalid = 1'b0;
      s_axis.tready = 1'b1;
      if (fwd) begin
         m_axis.tvalid = s_axis.tvalid;
         s_axis.tready = m_axis.tready;
      end
      case (state)
         IDLE:     if (sh_en) state_nxt = WAIT_SOF;
         WAIT_SOF: begin
            if (!sh_en)    state_nxt = IDLE;
            else if (fire) state_nxt = ACTIVE;
         end
         ACTIVE:   state_nxt = ACTIVE;
         default:  state_nxt = IDLE;
      endcase
      // A 1x1 frame can both start and end on the same beat.
      if (eof) state_nxt = sh_en ? WAIT_SOF : IDLE;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sh_en        <= 1'b0;
         sh_col       <= 1'b0;
         sh_line      <= 1'b0;
         sh_width     <= '0;
         sh_height    <= '0;
         act_width    <= '0;
         act_height   <= '0;
         ds_col_down  <= 1'b0;
         ds_line_down <= 1'b0;
         beat_cnt     <= '0;
         line_cnt     <= '0;
         frame_cnt    <= '0;
         err_line_len <= 1'b0;
         err_frame    <= 1'b0;
      end else begin
         if (cfg_wr) begin
            sh_en     <= cfg_enable;
            sh_col    <= cfg_col_down;
            sh_line   <= cfg_line_down;
            sh_width  <= cfg_width;
            sh_height <= cfg_height;
         end
         if (fire) begin
            if (sof) begin
               act_width    <= cur_w;
               act_height   <= cur_h;
               ds_col_down  <= sh_col;
               ds_line_down <= sh_line;
            end
            if (s_axis.tlast)          beat_cnt <= '0;
            else if (beat_idx != '1)   beat_cnt <= beat_idx + ONE;
            else                       beat_cnt <= beat_idx;
            if (eof)                   line_cnt <= '0;
            else if (s_axis.tlast)     line_cnt <= line_idx + ONE;
            else                       line_cnt <= line_idx;
            if (eof) frame_cnt <= frame_cnt + ONE;
         end
         if (line_err)     err_line_len <= 1'b1;
         else if (err_clr) err_line_len <= 1'b0;
         if (fire && sof && state == ACTIVE) err_frame <= 1'b1;
         else if (err_clr)                   err_frame <= 1'b0;
      end
   end
endmodule

// File: tb/tb_v_dsampler_ctrl.sv
// Scoreboard bench for v_dsampler_ctrl: forwarded beats are queued when driven and matched at the master side.
module tb_v_dsampler_ctrl;
   localparam int DW = 48;
   localparam int CW = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          cfg_wr = 1'b0, cfg_enable = 1'b0, cfg_col_down = 1'b0, cfg_line_down = 1'b0;
   logic [CW-1:0] cfg_width = '0, cfg_height = '0;
   logic          err_clr = 1'b0;
   logic          ds_col_down, ds_line_down, err_line_len, err_frame, busy;
   logic [CW-1:0] frame_cnt;

   v_dsampler_ctrl_if #(.DATA_WIDTH(DW)) s_if ();
   v_dsampler_ctrl_if #(.DATA_WIDTH(DW)) m_if ();

   v_dsampler_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cfg_wr(cfg_wr), .cfg_enable(cfg_enable), .cfg_col_down(cfg_col_down),
      .cfg_line_down(cfg_line_down), .cfg_width(cfg_width), .cfg_height(cfg_height),
      .err_clr(err_clr), .s_axis(s_if), .m_axis(m_if),
      .ds_col_down(ds_col_down), .ds_line_down(ds_line_down), .frame_cnt(frame_cnt),
      .err_line_len(err_line_len), .err_frame(err_frame), .busy(busy)
   );

   always #5 aclk = ~aclk;

   logic [DW+1:0] exp_q[$];
   bit            rdy_q[$];
   int            vectors = 0;
   int            miscompares = 0;
   int            exp_frames = 0;

   always @(negedge aclk) begin
      if (aresetn && m_if.tvalid && m_if.tready) begin
         logic [DW+1:0] got, want;
         got = {m_if.tuser, m_if.tlast, m_if.tdata};
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL fwd_beat unexpected beat got=%h", got);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               miscompares++;
               $display("FAIL fwd_beat got=%h exp=%h", got, want);
            end
         end
      end
   end

   task automatic cfg_write(input bit en, input bit col, input bit line, input int w, input int h);
      cfg_enable = en; cfg_col_down = col; cfg_line_down = line;
      cfg_width = CW'(w); cfg_height = CW'(h); cfg_wr = 1'b1;
      @(posedge aclk); #1;
      cfg_wr = 1'b0;
      @(posedge aclk); #1;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit user, input bit fwd);
      bit acc = 1'b0;
      s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tlast = last; s_if.tuser = user;
      if (fwd) exp_q.push_back({user, last, d});
      for (int i = 0; i < 50 && !acc; i++) begin
         m_if.tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
         @(negedge aclk);
         vectors++;
         if (fwd && s_if.tready !== m_if.tready) begin
            miscompares++;
            $display("FAIL ready_mirror s_tready=%b m_tready=%b", s_if.tready, m_if.tready);
         end else if (!fwd && (s_if.tready !== 1'b1 || m_if.tvalid !== 1'b0)) begin
            miscompares++;
            $display("FAIL discard s_tready=%b m_tvalid=%b exp 1/0", s_if.tready, m_if.tvalid);
         end
         acc = (s_if.tready === 1'b1);
         @(posedge aclk); #1;
      end
      if (!acc) begin
         miscompares++;
         $display("FAIL beat_timeout beat not accepted within 50 cycles");
      end
      s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
      m_if.tready = 1'b1;
   endtask

   task automatic send_line(input int n, input int last_at, input bit sof, input bit fwd);
      logic [63:0] r;
      for (int i = 0; i < n; i++) begin
         r = {$urandom, $urandom};
         send_beat(r[DW-1:0], i == last_at, sof && i == 0, fwd);
      end
   endtask

   task automatic test_reset();
      s_if.tvalid = 1'b1; s_if.tuser = 1'b1; s_if.tlast = 1'b0; s_if.tdata = '0;
      m_if.tready = 1'b1;
      #2;
      vectors++;
      if ({busy, frame_cnt, ds_col_down, ds_line_down, err_line_len, err_frame} !== '0) begin
         miscompares++;
         $display("FAIL reset_state busy=%b frame=%0d col=%b line=%b el=%b ef=%b exp all 0",
                  busy, frame_cnt, ds_col_down, ds_line_down, err_line_len, err_frame);
      end
      vectors++;
      if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_handshake m_tvalid=%b s_tready=%b exp 0/1", m_if.tvalid, s_if.tready);
      end
      s_if.tvalid = 1'b0; s_if.tuser = 1'b0;
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk); #1;
   endtask

   task automatic test_frame();
      cfg_write(1, 1, 1, 4, 2);
      vectors++;
      if (ds_col_down !== 1'b0 || ds_line_down !== 1'b0) begin
         miscompares++;
         $display("FAIL shadow_only col=%b line=%b exp 0/0", ds_col_down, ds_line_down);
      end
      send_line(1, -1, 1, 1);
      vectors++;
      if (ds_col_down !== 1'b1 || ds_line_down !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL sof_load col=%b line=%b busy=%b exp 1/1/1", ds_col_down, ds_line_down, busy);
      end
      send_line(3, 2, 0, 1);
      send_line(4, 3, 0, 1);
      exp_frames++;
      vectors++;
      if (frame_cnt !== CW'(exp_frames) || err_line_len !== 1'b0 || err_frame !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL frame_done frame=%0d el=%b ef=%b busy=%b exp %0d/0/0/0",
                  frame_cnt, err_line_len, err_frame, busy, exp_frames);
      end
   endtask

   task automatic test_garbage();
      send_line(3, 1, 0, 0);
      send_line(4, 3, 1, 1);
      send_line(4, 3, 0, 1);
      exp_frames++;
      vectors++;
      if (frame_cnt !== CW'(exp_frames)) begin
         miscompares++;
         $display("FAIL garbage_frame frame=%0d exp %0d", frame_cnt, exp_frames);
      end
   endtask

   task automatic test_back_to_back();
      rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      send_line(4, 3, 1, 1);
      send_line(4, 3, 0, 1);
      exp_frames++;
      vectors++;
      if (frame_cnt !== CW'(exp_frames) || err_line_len !== 1'b0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL backpressure frame=%0d el=%b pending=%0d exp %0d/0/0",
                  frame_cnt, err_line_len, exp_q.size(), exp_frames);
      end
   endtask

   task automatic test_line_err();
      send_line(3, 2, 1, 1);
      vectors++;
      if (err_line_len !== 1'b1) begin
         miscompares++;
         $display("FAIL line_err_set el=%b exp 1", err_line_len);
      end
      send_line(4, 3, 0, 1);
      exp_frames++;
      repeat (3) @(posedge aclk);
      #1;
      vectors++;
      if (err_line_len !== 1'b1 || frame_cnt !== CW'(exp_frames) || err_frame !== 1'b0) begin
         miscompares++;
         $display("FAIL line_err_sticky el=%b frame=%0d ef=%b exp 1/%0d/0", err_line_len, frame_cnt, err_frame, exp_frames);
      end
      err_clr = 1'b1;
      @(posedge aclk); #1;
      err_clr = 1'b0;
      vectors++;
      if (err_line_len !== 1'b0) begin
         miscompares++;
         $display("FAIL line_err_clr el=%b exp 0", err_line_len);
      end
   endtask

   task automatic test_frame_err();
      send_line(4, 3, 1, 1);
      send_line(1, -1, 1, 1);
      vectors++;
      if (err_frame !== 1'b1 || frame_cnt !== CW'(exp_frames) || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL frame_err_set ef=%b frame=%0d busy=%b exp 1/%0d/1", err_frame, frame_cnt, busy, exp_frames);
      end
      send_line(3, 2, 0, 1);
      send_line(4, 3, 0, 1);
      exp_frames++;
      vectors++;
      if (frame_cnt !== CW'(exp_frames) || err_line_len !== 1'b0) begin
         miscompares++;
         $display("FAIL frame_err_restart frame=%0d el=%b exp %0d/0", frame_cnt, err_line_len, exp_frames);
      end
      err_clr = 1'b1;
      @(posedge aclk); #1;
      err_clr = 1'b0;
   endtask

   task automatic test_cfg_midframe();
      send_line(2, -1, 1, 1);
      cfg_write(1, 0, 1, 4, 2);
      send_line(2, 1, 0, 1);
      vectors++;
      if (ds_col_down !== 1'b1) begin
         miscompares++;
         $display("FAIL cfg_midframe col=%b exp 1", ds_col_down);
      end
      send_line(4, 3, 0, 1);
      exp_frames++;
      send_line(2, -1, 1, 1);
      vectors++;
      if (ds_col_down !== 1'b0 || ds_line_down !== 1'b1) begin
         miscompares++;
         $display("FAIL cfg_next_sof col=%b line=%b exp 0/1", ds_col_down, ds_line_down);
      end
      s_if.tvalid = 1'b1; s_if.tuser = 1'b1;
      #3 aresetn = 1'b0;
      #1;
      vectors++;
      if ({busy, frame_cnt, ds_col_down, ds_line_down, err_line_len, err_frame} !== '0 ||
          m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1) begin
         miscompares++;
         $display("FAIL async_reset busy=%b frame=%0d col=%b line=%b m_tvalid=%b s_tready=%b exp 0/0/0/0/0/1",
                  busy, frame_cnt, ds_col_down, ds_line_down, m_if.tvalid, s_if.tready);
      end
      s_if.tvalid = 1'b0; s_if.tuser = 1'b0;
      exp_q.delete();
      exp_frames = 0;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(posedge aclk); #1;
   endtask

   task automatic test_zero_geometry();
      cfg_write(1, 0, 0, 0, 0);
      send_beat(48'h0000_1234_5678, 1'b1, 1'b1, 1'b1);
      exp_frames++;
      vectors++;
      if (frame_cnt !== CW'(exp_frames) || err_line_len !== 1'b0 || err_frame !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_geom frame=%0d el=%b ef=%b busy=%b exp %0d/0/0/0",
                  frame_cnt, err_line_len, err_frame, busy, exp_frames);
      end
      cfg_write(1, 1, 1, 4, 2);
      send_line(2, 1, 0, 0);
      send_line(4, 3, 1, 1);
      send_line(4, 3, 0, 1);
      exp_frames++;
      vectors++;
      if (frame_cnt !== CW'(exp_frames) || ds_col_down !== 1'b1 || err_line_len !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_frame frame=%0d col=%b el=%b exp %0d/1/0",
                  frame_cnt, ds_col_down, err_line_len, exp_frames);
      end
   endtask

   initial begin
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
      m_if.tready = 1'b1;
      test_reset();
      test_frame();
      test_garbage();
      test_back_to_back();
      test_line_err();
      test_frame_err();
      test_cfg_midframe();
      test_zero_geometry();
      repeat (2) @(posedge aclk);
      #1;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain pending=%0d exp 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
